// File: rtl/ibex_sram_arb.sv
// Round-robin arbiter that lets the Ibex instruction and data hosts share one
// single-port RAM. It returns one response per grant, flags out-of-window accesses, and counts stall cycles.
`timescale 1ns/1ps

module ibex_sram_arb #(
  parameter logic [31:0] MemBase = 32'h0010_0000,
  parameter int unsigned MemSize = 65536,
  localparam int unsigned Depth  = MemSize / 4,
  localparam int unsigned AddrW  = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,

  input  logic             instr_req_i,
  output logic             instr_gnt_o,
  output logic             instr_rvalid_o,
  input  logic [31:0]      instr_addr_i,
  output logic [31:0]      instr_rdata_o,
  output logic             instr_err_o,

  input  logic             data_req_i,
  output logic             data_gnt_o,
  output logic             data_rvalid_o,
  input  logic             data_we_i,
  input  logic [3:0]       data_be_i,
  input  logic [31:0]      data_addr_i,
  input  logic [31:0]      data_wdata_i,
  output logic [31:0]      data_rdata_o,
  output logic             data_err_o,

  output logic             ram_req_o,
  output logic             ram_we_o,
  output logic [3:0]       ram_be_o,
  output logic [AddrW-1:0] ram_addr_o,
  output logic [31:0]      ram_wdata_o,
  input  logic             ram_rvalid_i,
  input  logic [31:0]      ram_rdata_i,

  output logic [15:0]      stall_cnt_o
);

  localparam logic [31:0] MemSizeW = 32'(MemSize);

  logic [31:0] instr_off, data_off;
  logic        instr_in_range, data_in_range;
  logic        instr_gnt, data_gnt, any_gnt, gnt_err, stall;

  logic        prio_q;        // 0: data wins a conflict, 1: instr wins
  logic        resp_valid_q;
  logic        resp_owner_q;  // 0: data, 1: instr
  logic        resp_err_q;
  logic [15:0] stall_cnt_q;

  // The subtraction wraps, so addresses below MemBase land far out of range.
  assign instr_off      = instr_addr_i - MemBase;
  assign data_off       = data_addr_i - MemBase;
  assign instr_in_range = instr_off < MemSizeW;
  assign data_in_range  = data_off < MemSizeW;

  // Grants are qualified with rst_ni so nothing is granted while in reset.
  assign data_gnt  = rst_ni & data_req_i & (~instr_req_i | ~prio_q);
  assign instr_gnt = rst_ni & instr_req_i & (~data_req_i | prio_q);
  assign any_gnt   = data_gnt | instr_gnt;
  assign gnt_err   = data_gnt ? ~data_in_range : ~instr_in_range;
  assign stall     = (instr_req_i & ~instr_gnt) | (data_req_i & ~data_gnt);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    ram_req_o   = 1'b0;
    ram_we_o    = 1'b0;
    ram_be_o    = 4'h0;
    ram_addr_o  = '0;
    ram_wdata_o = 32'h0;
    if (data_gnt && data_in_range) begin
      ram_req_o   = 1'b1;
      ram_we_o    = data_we_i;
      ram_be_o    = data_be_i;
      ram_addr_o  = data_off[AddrW+1:2];
      ram_wdata_o = data_wdata_i;
    end else if (instr_gnt && instr_in_range) begin
      ram_req_o  = 1'b1;
      ram_addr_o = instr_off[AddrW+1:2];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_owner_q <= 1'b0;
      resp_err_q   <= 1'b0;
      stall_cnt_q  <= 16'h0;
    end else begin
      resp_valid_q <= any_gnt;
      if (any_gnt) begin
        prio_q       <= data_gnt;
        resp_owner_q <= instr_gnt;
        resp_err_q   <= gnt_err;
      end
      if (stall && stall_cnt_q != 16'hFFFF) begin
        stall_cnt_q <= stall_cnt_q + 16'h1;
      end
    end
  end

  assign instr_gnt_o    = instr_gnt;
  assign data_gnt_o     = data_gnt;
  assign instr_rvalid_o = resp_valid_q & resp_owner_q;
  assign data_rvalid_o  = resp_valid_q & ~resp_owner_q;
  assign instr_err_o    = resp_valid_q & resp_owner_q & resp_err_q;
  assign data_err_o     = resp_valid_q & ~resp_owner_q & resp_err_q;
  assign instr_rdata_o  = (resp_valid_q & resp_owner_q & ~resp_err_q) ? ram_rdata_i : 32'h0;
  assign data_rdata_o   = (resp_valid_q & ~resp_owner_q & ~resp_err_q) ? ram_rdata_i : 32'h0;
  assign stall_cnt_o    = stall_cnt_q;

  // The RAM must answer exactly the in-range accesses granted one cycle earlier.
  ram_rvalid_chk: assert property (@(posedge clk_i) disable iff (!rst_ni)
    ram_rvalid_i == (resp_valid_q && !resp_err_q));

endmodule

// File: tb/tb_ibex_sram_arb.sv
// Self-checking bench for ibex_sram_arb: directed vector table, multi-cycle
// corner sequences, then random traffic against a transaction-level model.
`timescale 1ns/1ps

module tb_ibex_sram_arb;

  localparam logic [31:0] BASE  = 32'h0010_0000;
  localparam int unsigned SIZE  = 65536;
  localparam int unsigned DEPTH = SIZE / 4;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam logic T = 1'b1;
  localparam logic F = 1'b0;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b1;
  logic          instr_req_i = 1'b0, instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0]   instr_addr_i = 32'h0, instr_rdata_o;
  logic          data_req_i = 1'b0, data_gnt_o, data_rvalid_o, data_we_i = 1'b0, data_err_o;
  logic [3:0]    data_be_i = 4'h0;
  logic [31:0]   data_addr_i = 32'h0, data_wdata_i = 32'h0, data_rdata_o;
  logic          ram_req_o, ram_we_o, ram_rvalid_i;
  logic [3:0]    ram_be_o;
  logic [AW-1:0] ram_addr_o;
  logic [31:0]   ram_wdata_o, ram_rdata_i;
  logic [15:0]   stall_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  ibex_sram_arb #(.MemBase(BASE), .MemSize(SIZE)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
    .instr_addr_i(instr_addr_i), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_we_i(data_we_i), .data_be_i(data_be_i), .data_addr_i(data_addr_i),
    .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .ram_req_o(ram_req_o), .ram_we_o(ram_we_o), .ram_be_o(ram_be_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rvalid_i(ram_rvalid_i), .ram_rdata_i(ram_rdata_i),
    .stall_cnt_o(stall_cnt_o)
  );

  // One-cycle-latency RAM; contents are cleared by reset so every phase starts blank.
  logic [31:0] ram_mem [DEPTH];
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ram_rvalid_i <= 1'b0;
      ram_rdata_i  <= 32'h0;
      for (int i = 0; i < DEPTH; i++) ram_mem[i] <= 32'h0;
    end else begin
      ram_rvalid_i <= ram_req_o;
      if (ram_req_o) begin
        ram_rdata_i <= ram_mem[ram_addr_o];
        if (ram_we_o)
          for (int b = 0; b < 4; b++)
            if (ram_be_o[b]) ram_mem[ram_addr_o][8*b +: 8] <= ram_wdata_o[8*b +: 8];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ireq, input logic [31:0] iaddr, input logic dreq,
                       input logic dwe, input logic [3:0] dbe, input logic [31:0] daddr,
                       input logic [31:0] dwdata);
    instr_req_i = ireq; instr_addr_i = iaddr;
    data_req_i = dreq; data_we_i = dwe; data_be_i = dbe;
    data_addr_i = daddr; data_wdata_i = dwdata;
  endtask

  task automatic do_reset();
    drive(F, 32'h0, F, F, 4'h0, 32'h0, 32'h0);
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic ireq; logic [31:0] iaddr; logic dreq; logic dwe; logic [3:0] dbe;
    logic [31:0] daddr; logic [31:0] dwdata;
  } in_t;
  typedef struct {
    logic igt; logic dgt; logic rreq; logic [31:0] raddr; logic rwe; logic [3:0] rbe;
    logic [31:0] rwdata; logic irv; logic ierr; logic [31:0] irdata;
    logic drv; logic derr; logic [31:0] drdata; logic chk_rd; logic [15:0] stall;
  } exp_t;
  typedef struct { in_t in; exp_t ex; } vec_t;

  localparam in_t IDLE = '{F, 32'h0, F, F, 4'h0, 32'h0, 32'h0};
  vec_t tbl [13];

  // ---------------- transaction-level reference model ----------------
  typedef enum logic {HOST_DATA, HOST_INSTR} host_e;
  typedef struct {
    logic valid; host_e owner; logic err; logic chk_rdata; logic [31:0] rdata;
  } resp_t;

  logic [31:0] gmem [int];
  host_e       last_gnt, win;
  resp_t       exp_resp;
  int          model_stall;
  logic        ip, dp, have_win, win_in, win_we;
  logic [31:0] ia, da, dw, waddr, word;
  logic [3:0]  db;
  logic        dwe_r;

  function automatic logic in_window(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off < SIZE;
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return BASE + SIZE + 4 * $urandom_range(0, 15);
      1:       return BASE - 4 * $urandom_range(1, 16);
      default: return BASE + 4 * $urandom_range(0, 31);
    endcase
  endfunction

  initial begin
    #1;
    do_reset();

    // Rows run back to back from reset; each row's response columns belong to the row above.
    tbl[0]  = '{'{F, 32'h0, T, T, 4'hF, BASE + 32'h10, 32'hDEADBEEF},
                '{F, T, T, 32'd4, T, 4'hF, 32'hDEADBEEF, F, F, 32'h0, F, F, 32'h0, T, 16'd0}};
    tbl[1]  = '{'{F, 32'h0, T, F, 4'hF, BASE + 32'h10, 32'h0},
                '{F, T, T, 32'd4, F, 4'hF, 32'h0, F, F, 32'h0, T, F, 32'h0, F, 16'd0}};
    tbl[2]  = '{'{T, BASE + SIZE, F, F, 4'h0, 32'h0, 32'h0},
                '{T, F, F, 32'd0, F, 4'h0, 32'h0, F, F, 32'h0, T, F, 32'hDEADBEEF, T, 16'd0}};
    tbl[3]  = '{'{F, 32'h0, T, F, 4'h0, BASE - 32'h4, 32'h0},
                '{F, T, F, 32'd0, F, 4'h0, 32'h0, T, T, 32'h0, F, F, 32'h0, T, 16'd0}};
    tbl[4]  = '{IDLE,
                '{F, F, F, 32'd0, F, 4'h0, 32'h0, F, F, 32'h0, T, T, 32'h0, T, 16'd0}};
    tbl[5]  = '{'{T, BASE + 32'h10, F, F, 4'h0, 32'h0, 32'h0},
                '{T, F, T, 32'd4, F, 4'h0, 32'h0, F, F, 32'h0, F, F, 32'h0, T, 16'd0}};
    tbl[6]  = '{IDLE,
                '{F, F, F, 32'd0, F, 4'h0, 32'h0, T, F, 32'hDEADBEEF, F, F, 32'h0, T, 16'd0}};
    tbl[7]  = '{'{T, BASE + 32'h10, T, F, 4'hF, BASE + 32'h10, 32'h0},
                '{F, T, T, 32'd4, F, 4'hF, 32'h0, F, F, 32'h0, F, F, 32'h0, T, 16'd0}};
    tbl[8]  = '{'{T, BASE + 32'h10, F, F, 4'h0, 32'h0, 32'h0},
                '{T, F, T, 32'd4, F, 4'h0, 32'h0, F, F, 32'h0, T, F, 32'hDEADBEEF, T, 16'd1}};
    tbl[9]  = '{IDLE,
                '{F, F, F, 32'd0, F, 4'h0, 32'h0, T, F, 32'hDEADBEEF, F, F, 32'h0, T, 16'd1}};
    tbl[10] = '{'{F, 32'h0, T, T, 4'h2, BASE + 32'h10, 32'h0000_5500},
                '{F, T, T, 32'd4, T, 4'h2, 32'h0000_5500, F, F, 32'h0, F, F, 32'h0, T, 16'd1}};
    tbl[11] = '{'{F, 32'h0, T, F, 4'hF, BASE + 32'h10, 32'h0},
                '{F, T, T, 32'd4, F, 4'hF, 32'h0, F, F, 32'h0, T, F, 32'h0, F, 16'd1}};
    tbl[12] = '{IDLE,
                '{F, F, F, 32'd0, F, 4'h0, 32'h0, F, F, 32'h0, T, F, 32'hDEAD55EF, T, 16'd1}};

    for (int i = 0; i < 13; i++) begin
      @(negedge clk_i);
      drive(tbl[i].in.ireq, tbl[i].in.iaddr, tbl[i].in.dreq, tbl[i].in.dwe,
            tbl[i].in.dbe, tbl[i].in.daddr, tbl[i].in.dwdata);
      #1;
      check($sformatf("vec%0d instr_gnt", i), 32'(instr_gnt_o), 32'(tbl[i].ex.igt));
      check($sformatf("vec%0d data_gnt", i), 32'(data_gnt_o), 32'(tbl[i].ex.dgt));
      check($sformatf("vec%0d ram_req", i), 32'(ram_req_o), 32'(tbl[i].ex.rreq));
      if (tbl[i].ex.rreq) begin
        check($sformatf("vec%0d ram_addr", i), 32'(ram_addr_o), tbl[i].ex.raddr);
        check($sformatf("vec%0d ram_we", i), 32'(ram_we_o), 32'(tbl[i].ex.rwe));
        check($sformatf("vec%0d ram_be", i), 32'(ram_be_o), 32'(tbl[i].ex.rbe));
        check($sformatf("vec%0d ram_wdata", i), ram_wdata_o, tbl[i].ex.rwdata);
      end
      check($sformatf("vec%0d instr_rvalid", i), 32'(instr_rvalid_o), 32'(tbl[i].ex.irv));
      check($sformatf("vec%0d instr_err", i), 32'(instr_err_o), 32'(tbl[i].ex.ierr));
      check($sformatf("vec%0d data_rvalid", i), 32'(data_rvalid_o), 32'(tbl[i].ex.drv));
      check($sformatf("vec%0d data_err", i), 32'(data_err_o), 32'(tbl[i].ex.derr));
      if (tbl[i].ex.chk_rd) begin
        check($sformatf("vec%0d instr_rdata", i), instr_rdata_o, tbl[i].ex.irdata);
        check($sformatf("vec%0d data_rdata", i), data_rdata_o, tbl[i].ex.drdata);
      end
      check($sformatf("vec%0d stall_cnt", i), 32'(stall_cnt_o), 32'(tbl[i].ex.stall));
    end

    // Six cycles of continuous conflict straight out of reset: D,I,D,I,D,I.
    do_reset();
    check("rst stall_cnt", 32'(stall_cnt_o), 32'h0);
    check("rst data_rvalid", 32'(data_rvalid_o), 32'h0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_i);
      drive(T, BASE + 32'h10, T, F, 4'hF, BASE + 32'h20, 32'h0);
      #1;
      check($sformatf("conf%0d data_gnt", c), 32'(data_gnt_o), 32'(c % 2 == 0));
      check($sformatf("conf%0d instr_gnt", c), 32'(instr_gnt_o), 32'(c % 2 == 1));
      check($sformatf("conf%0d data_rvalid", c), 32'(data_rvalid_o), 32'(c % 2 == 1));
      check($sformatf("conf%0d instr_rvalid", c), 32'(instr_rvalid_o), 32'(c > 0 && c % 2 == 0));
      check($sformatf("conf%0d stall_cnt", c), 32'(stall_cnt_o), 32'(c));
    end
    @(negedge clk_i);
    drive(F, 32'h0, F, F, 4'h0, 32'h0, 32'h0);
    #1;
    check("conf end instr_rvalid", 32'(instr_rvalid_o), 32'h1);
    check("conf end stall_cnt", 32'(stall_cnt_o), 32'd6);

    // Reset in the cycle after a data grant drops that response entirely.
    @(negedge clk_i);
    drive(F, 32'h0, T, F, 4'hF, BASE + 32'h10, 32'h0);
    #1;
    check("mid data_gnt", 32'(data_gnt_o), 32'h1);
    @(negedge clk_i);
    rst_ni = 1'b0;
    drive(T, BASE + 32'h30, T, F, 4'hF, BASE + 32'h10, 32'h0);
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("inrst%0d data_rvalid", c), 32'(data_rvalid_o), 32'h0);
      check($sformatf("inrst%0d data_gnt", c), 32'(data_gnt_o), 32'h0);
      check($sformatf("inrst%0d instr_gnt", c), 32'(instr_gnt_o), 32'h0);
      check($sformatf("inrst%0d ram_req", c), 32'(ram_req_o), 32'h0);
      check($sformatf("inrst%0d stall_cnt", c), 32'(stall_cnt_o), 32'h0);
      @(negedge clk_i);
    end
    rst_ni = 1'b1;
    #1;
    check("post data_gnt", 32'(data_gnt_o), 32'h1);
    check("post instr_gnt", 32'(instr_gnt_o), 32'h0);
    check("post data_rvalid", 32'(data_rvalid_o), 32'h0);
    check("post stall_cnt", 32'(stall_cnt_o), 32'h0);
    @(negedge clk_i);
    drive(F, 32'h0, F, F, 4'h0, 32'h0, 32'h0);
    #1;
    check("post2 data_rvalid", 32'(data_rvalid_o), 32'h1);
    check("post2 stall_cnt", 32'(stall_cnt_o), 32'h1);

    // Stall counter saturation under permanent conflict.
    do_reset();
    @(negedge clk_i);
    drive(T, BASE + 32'h40, T, F, 4'hF, BASE + 32'h44, 32'h0);
    repeat (65540) @(negedge clk_i);
    #1;
    check("sat stall_cnt", 32'(stall_cnt_o), 32'h0000_FFFF);
    @(negedge clk_i);
    #1;
    check("sat hold stall_cnt", 32'(stall_cnt_o), 32'h0000_FFFF);

    // Random traffic; hosts hold a request until it is granted.
    do_reset();
    gmem.delete();
    last_gnt = HOST_INSTR;
    exp_resp = '{F, HOST_DATA, F, F, 32'h0};
    model_stall = 0;
    ip = F; dp = F;
    ia = 32'h0; da = 32'h0; dw = 32'h0; db = 4'h0; dwe_r = F;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk_i);
      if (!ip && $urandom_range(0, 2) != 0) begin
        ip = T; ia = rand_addr();
      end
      if (!dp && $urandom_range(0, 2) != 0) begin
        dp = T; da = rand_addr(); dwe_r = 1'($urandom_range(0, 1));
        db = 4'($urandom_range(1, 15)); dw = $urandom;
      end
      drive(ip, ia, dp, dwe_r, db, da, dw);
      #1;

      have_win = ip || dp;
      if (ip && dp) win = (last_gnt == HOST_DATA) ? HOST_INSTR : HOST_DATA;
      else          win = dp ? HOST_DATA : HOST_INSTR;
      waddr  = (win == HOST_DATA) ? da : ia;
      win_in = have_win && in_window(waddr);
      win_we = have_win && win == HOST_DATA && dwe_r;

      check("rnd data_gnt", 32'(data_gnt_o), 32'(have_win && win == HOST_DATA));
      check("rnd instr_gnt", 32'(instr_gnt_o), 32'(have_win && win == HOST_INSTR));
      check("rnd ram_req", 32'(ram_req_o), 32'(win_in));
      if (win_in) begin
        check("rnd ram_addr", 32'(ram_addr_o), (waddr - BASE) / 4);
        check("rnd ram_we", 32'(ram_we_o), 32'(win_we));
        check("rnd ram_be", 32'(ram_be_o), (win == HOST_DATA) ? 32'(db) : 32'h0);
        check("rnd ram_wdata", ram_wdata_o, (win == HOST_DATA) ? dw : 32'h0);
      end
      check("rnd instr_rvalid", 32'(instr_rvalid_o), 32'(exp_resp.valid && exp_resp.owner == HOST_INSTR));
      check("rnd data_rvalid", 32'(data_rvalid_o), 32'(exp_resp.valid && exp_resp.owner == HOST_DATA));
      check("rnd instr_err", 32'(instr_err_o),
            32'(exp_resp.valid && exp_resp.owner == HOST_INSTR && exp_resp.err));
      check("rnd data_err", 32'(data_err_o),
            32'(exp_resp.valid && exp_resp.owner == HOST_DATA && exp_resp.err));
      if (!(exp_resp.valid && exp_resp.owner == HOST_INSTR) || exp_resp.chk_rdata)
        check("rnd instr_rdata", instr_rdata_o,
              (exp_resp.valid && exp_resp.owner == HOST_INSTR) ? exp_resp.rdata : 32'h0);
      if (!(exp_resp.valid && exp_resp.owner == HOST_DATA) || exp_resp.chk_rdata)
        check("rnd data_rdata", data_rdata_o,
              (exp_resp.valid && exp_resp.owner == HOST_DATA) ? exp_resp.rdata : 32'h0);
      check("rnd stall_cnt", 32'(stall_cnt_o), 32'(model_stall));

      // Advance the model by one cycle.
      word = gmem.exists((waddr - BASE) / 4) ? gmem[(waddr - BASE) / 4] : 32'h0;
      exp_resp = '{have_win, win, have_win && !win_in, !(win_we && win_in),
                   win_in ? word : 32'h0};
      if (win_in && win_we) begin
        for (int b = 0; b < 4; b++) if (db[b]) word[8*b +: 8] = dw[8*b +: 8];
        gmem[(waddr - BASE) / 4] = word;
      end
      if (((ip && !(have_win && win == HOST_INSTR)) || (dp && !(have_win && win == HOST_DATA)))
          && model_stall < 65535)
        model_stall++;
      if (have_win) begin
        last_gnt = win;
        if (win == HOST_DATA) dp = F; else ip = F;
      end
    end

    @(negedge clk_i);
    drive(F, 32'h0, F, F, 4'h0, 32'h0, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ibex_sram_arb.md
IBEX_SRAM_ARB -- requirements
Module: ibex_sram_arb

Interface
REQ-001 SHALL have parameter MemBase, default 32'h0010_0000, byte base address of the RAM window.
REQ-002 SHALL have parameter MemSize, default 65536, RAM window size in bytes; must be a power of two and at least 8.
REQ-003 SHALL derive localparam Depth = MemSize/4 (32-bit words) and AddrW = $clog2(Depth).
REQ-004 SHALL have one clock, clk_i, and an asynchronous, active-low reset, rst_ni.
REQ-005 Instruction host ports, named from the Ibex side:
- instr_req_i (in, 1)
- instr_gnt_o (out, 1)
- instr_rvalid_o (out, 1)
- instr_addr_i (in, 32)
- instr_rdata_o (out, 32)
- instr_err_o (out, 1)
REQ-006 Data host ports:
- data_req_i (in, 1)
- data_gnt_o (out, 1)
- data_rvalid_o (out, 1)
- data_we_i (in, 1)
- data_be_i (in, 4)
- data_addr_i (in, 32)
- data_wdata_i (in, 32)
- data_rdata_o (out, 32)
- data_err_o (out, 1)
REQ-007 RAM device ports, matching ram_1p:
- ram_req_o (out, 1)
- ram_we_o (out, 1)
- ram_be_o (out, 4)
- ram_addr_o (out, AddrW), word address
- ram_wdata_o (out, 32)
- ram_rvalid_i (in, 1)
- ram_rdata_i (in, 32)
REQ-008 stall_cnt_o (out, 16): saturating count of cycles in which a requester was refused a grant.

Function
REQ-009 In range: addr[31:0] - MemBase < MemSize, computed unsigned in 32 bits so the comparison wraps.
REQ-010 Grants are issued combinationally in the request cycle.
- At most one of instr_gnt_o and data_gnt_o is high per cycle.
- A lone requester is always granted.
REQ-011 When both hosts request in the same cycle, the host selected by prio_q is granted.
- prio_q = 0 selects data; prio_q = 1 selects instr.
REQ-012 After every grant, prio_q is loaded to point at the host that was not granted (round-robin).
REQ-013 An in-range grant drives the RAM in the same cycle:
- ram_req_o = 1;
- ram_addr_o = (addr - MemBase) >> 2, truncated to AddrW bits;
- ram_we_o, ram_be_o and ram_wdata_o come from the data host; they are 0 for an instr grant.
REQ-014 An out-of-range grant does not assert ram_req_o; it is recorded as an error response.
REQ-015 Response registers, loaded on every grant: resp_valid_q, resp_owner_q (0 = data, 1 = instr) and resp_err_q.
REQ-016 Exactly one cycle after a grant, the owner's rvalid is asserted for one cycle; writes also receive rvalid.
REQ-017 Owner rdata and err in the response cycle:
- rdata = ram_rdata_i when resp_err_q = 0, else 32'h0;
- err = resp_err_q.
REQ-018 When not in its response cycle, a host's rvalid, err and rdata are 0.
REQ-019 A grant is allowed in the same cycle as a response (back-to-back, one access per cycle).
REQ-020 In a cycle where a host has req high and gnt low, stall_cnt_o increments by 1.
- If both hosts are refused, the increment is still 1.
- The count saturates at 16'hFFFF.
REQ-021 Hosts must hold their request signals stable until granted; the block does not buffer refused requests.
REQ-022 Assertion: ram_rvalid_i == (resp_valid_q && !resp_err_q) in every cycle.

Reset
REQ-023 On rst_ni low, immediately and asynchronously:
- prio_q = 0;
- resp_valid_q, resp_owner_q and resp_err_q = 0;
- stall_cnt_o = 0.
REQ-024 During reset all gnt, rvalid, err and ram_req_o outputs SHALL be 0.
- The combinational grant path is gated with the reset state.
REQ-025 Reset mid-transaction discards any pending response; no rvalid is produced for that access after reset is released.

Verification
REQ-026 Lone data write: addr=MemBase+0x10, be=4'hF, wdata=32'hDEADBEEF.
- Same cycle: data_gnt_o=1, ram_addr_o=4, ram_we_o=1.
- Next cycle: data_rvalid_o=1, data_err_o=0.
REQ-027 Both hosts request in-range reads in the same cycle from reset.
- Cycle 0: data is granted and instr_gnt_o=0; stall_cnt_o reads 1 in the following cycle.
- Cycle 1: instr is granted while data_rvalid_o=1.
- Cycle 2: instr_rvalid_o=1.
REQ-028 Continuous conflicting requests for 6 cycles.
- Grants alternate D,I,D,I,D,I.
- stall_cnt_o = 6 afterwards.
REQ-029 Instr fetch at MemBase+MemSize (just out of range).
- instr_gnt_o=1 and ram_req_o=0.
- Next cycle: instr_rvalid_o=1, instr_err_o=1, instr_rdata_o=0.
REQ-030 Data read from MemBase-4 (wrapped difference) -> data_err_o=1 in the response cycle.
REQ-031 Assert rst_ni in the cycle after a data grant.
- No data_rvalid_o ever appears for that access.
- After release, prio_q=0 (data wins the next conflict) and stall_cnt_o=0.
